// File: rtl/sprite_eval.sv
// sprite_eval: per-scanline sprite evaluator.
// Holds primary OAM (N_SPRITES x 4 bytes) behind a CPU OAMADDR/OAMDATA port,
// and on eval_start builds secondary OAM (N_SLOTS x 4 bytes) for scan_line.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cpu_addr_we         load OAMADDR from cpu_wdata
//   cpu_data_we         write cpu_wdata to OAM[OAMADDR], OAMADDR++ (dropped while busy)
//   cpu_wdata           CPU write data
//   cpu_rdata           OAM[OAMADDR], registered; attribute bits 4:2 read as 0
//   eval_start          begin (or restart) evaluation of scan_line
//   scan_line, tall     line to evaluate, 8/16-pixel sprite height select
//   eval_busy           evaluation in progress
//   eval_done           one-cycle completion pulse
//   sp_count            secondary slots filled
//   sp_overflow         more than N_SLOTS sprites on the line
//   sp0_in_range        sprite 0 landed in slot 0
//   sec_idx, sec_data   secondary OAM read port, 1-cycle latency
//
// state   | meaning
// S_IDLE  | waiting for eval_start
// S_CLEAR | fill secondary OAM with 8'hFF, one byte per cycle
// S_FETCH | read OAM[n*4+m] into rd
// S_STORE | Y-range test (m==0) or byte copy (m=1..3)
// S_DONE  | eval_done pulse, back to idle
module sprite_eval #(
   parameter int N_SPRITES = 64,
   parameter int N_SLOTS   = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cpu_addr_we,
   input  logic                            cpu_data_we,
   input  logic [7:0]                      cpu_wdata,
   output logic [7:0]                      cpu_rdata,
   input  logic                            eval_start,
   input  logic [7:0]                      scan_line,
   input  logic                            tall,
   output logic                            eval_busy,
   output logic                            eval_done,
   output logic [$clog2(N_SLOTS+1)-1:0]    sp_count,
   output logic                            sp_overflow,
   output logic                            sp0_in_range,
   input  logic [$clog2(N_SLOTS*4)-1:0]    sec_idx,
   output logic [7:0]                      sec_data
);

   localparam int OAM_AW = $clog2(N_SPRITES*4);
   localparam int N_AW   = $clog2(N_SPRITES);
   localparam int SEC_AW = $clog2(N_SLOTS*4);
   localparam int CNT_W  = $clog2(N_SLOTS+1);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_STORE, S_DONE} state_t;

   state_t              state, state_nx;
   logic [7:0]          oam [N_SPRITES*4];
   logic [7:0]          sec [N_SLOTS*4];
   logic [OAM_AW-1:0]   oam_addr;
   logic [7:0]          line_l;
   logic                tall_l;
   logic [N_AW-1:0]     n;
   logic [1:0]          m;
   logic [SEC_AW-1:0]   clr_idx;
   logic [7:0]          rd;
   logic [8:0]          diff;
   logic                hit, last_n, last_clr, slot_free;
   logic                sec_we;
   logic [SEC_AW-1:0]   sec_waddr;
   logic [7:0]          sec_wdata;

   // 9-bit subtraction: a borrow in diff[8] means the sprite starts below the line
   assign diff      = {1'b0, line_l} - {1'b0, rd};
   assign hit       = !diff[8] && (diff < (tall_l ? 9'd16 : 9'd8));
   assign last_n    = (n == N_AW'(N_SPRITES-1));
   assign last_clr  = (clr_idx == SEC_AW'(N_SLOTS*4-1));
   assign slot_free = (sp_count < CNT_W'(N_SLOTS));

   // CPU port
   always_ff @(posedge clk) begin
      if (rst)
         oam_addr <= '0;
      else if (cpu_addr_we)
         oam_addr <= OAM_AW'(cpu_wdata);
      else if (cpu_data_we && !eval_busy)
         oam_addr <= oam_addr + OAM_AW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst && !cpu_addr_we && cpu_data_we && !eval_busy)
         oam[oam_addr] <= cpu_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cpu_rdata <= '0;
      else if (oam_addr[1:0] == 2'd2)
         cpu_rdata <= oam[oam_addr] & 8'hE3;
      else
         cpu_rdata <= oam[oam_addr];
   end

   // FSM
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (eval_start)
         state_nx = S_CLEAR;
      else begin
         case (state)
            S_IDLE:  state_nx = S_IDLE;
            S_CLEAR: if (last_clr) state_nx = S_FETCH;
            S_FETCH: state_nx = S_STORE;
            S_STORE: begin
               if (m == 2'd0) begin
                  if (hit)
                     state_nx = slot_free ? S_FETCH : S_DONE;
                  else
                     state_nx = last_n ? S_DONE : S_FETCH;
               end else begin
                  state_nx = (m == 2'd3 && last_n) ? S_DONE : S_FETCH;
               end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_comb begin
      eval_busy = (state == S_CLEAR) || (state == S_FETCH) || (state == S_STORE);
      eval_done = (state == S_DONE);
   end

   // Secondary OAM write port: CLEAR fill or STORE copy
   always_comb begin
      sec_we    = 1'b0;
      sec_waddr = clr_idx;
      sec_wdata = 8'hFF;
      if (!eval_start) begin
         if (state == S_CLEAR)
            sec_we = 1'b1;
         else if (state == S_STORE && (m != 2'd0 || (hit && slot_free))) begin
            sec_we    = 1'b1;
            sec_waddr = SEC_AW'({sp_count, m});
            sec_wdata = rd;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (sec_we)
         sec[sec_waddr] <= sec_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst)
         sec_data <= '0;
      else
         sec_data <= sec[sec_idx];
   end

   // Scan datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         line_l       <= '0;
         tall_l       <= 1'b0;
         n            <= '0;
         m            <= '0;
         clr_idx      <= '0;
         rd           <= '0;
         sp_count     <= '0;
         sp_overflow  <= 1'b0;
         sp0_in_range <= 1'b0;
      end else if (eval_start) begin
         line_l       <= scan_line;
         tall_l       <= tall;
         n            <= '0;
         m            <= '0;
         clr_idx      <= '0;
         sp_count     <= '0;
         sp_overflow  <= 1'b0;
         sp0_in_range <= 1'b0;
      end else begin
         case (state)
            S_CLEAR: clr_idx <= clr_idx + SEC_AW'(1);
            S_FETCH: rd <= oam[{n, m}];
            S_STORE: begin
               if (m == 2'd0) begin
                  if (hit) begin
                     if (slot_free) begin
                        m <= 2'd1;
                        if (n == '0) sp0_in_range <= 1'b1;
                     end else begin
                        sp_overflow <= 1'b1;
                     end
                  end else begin
                     n <= n + N_AW'(1);
                  end
               end else if (m == 2'd3) begin
                  m        <= 2'd0;
                  n        <= n + N_AW'(1);
                  sp_count <= sp_count + CNT_W'(1);
               end else begin
                  m <= m + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_eval.sv
module tb_sprite_eval;

   localparam int NSP = 64;
   localparam int NSL = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cpu_addr_we = 1'b0;
   logic       cpu_data_we = 1'b0;
   logic [7:0] cpu_wdata = '0;
   logic [7:0] cpu_rdata;
   logic       eval_start = 1'b0;
   logic [7:0] scan_line = '0;
   logic       tall = 1'b0;
   logic       eval_busy, eval_done;
   logic [3:0] sp_count;
   logic       sp_overflow, sp0_in_range;
   logic [4:0] sec_idx = '0;
   logic [7:0] sec_data;

   sprite_eval #(.N_SPRITES(NSP), .N_SLOTS(NSL)) dut (
      .clk(clk), .rst(rst),
      .cpu_addr_we(cpu_addr_we), .cpu_data_we(cpu_data_we),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .eval_start(eval_start), .scan_line(scan_line), .tall(tall),
      .eval_busy(eval_busy), .eval_done(eval_done),
      .sp_count(sp_count), .sp_overflow(sp_overflow), .sp0_in_range(sp0_in_range),
      .sec_idx(sec_idx), .sec_data(sec_data)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // reference model state
   logic [7:0] oam_m [NSP*4];
   logic [7:0] exp_sec [NSL*4];
   int         exp_cnt, exp_lat;
   bit         exp_ovf, exp_sp0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step();
      tick();
      cyc++;
   endtask

   function automatic logic [7:0] rmask(input int a, input logic [7:0] d);
      return (a % 4 == 2) ? (d & 8'hE3) : d;
   endfunction

   // Evaluation rules in plain arithmetic: walk sprites in order, copy the
   // first NSL in range, stop on the first extra one.
   task automatic eval_model(input int line, input bit t);
      int h;
      int y;
      h       = t ? 16 : 8;
      exp_cnt = 0;
      exp_ovf = 0;
      exp_sp0 = 0;
      exp_lat = NSL*4 + 1;
      for (int i = 0; i < NSL*4; i++) exp_sec[i] = 8'hFF;
      for (int s = 0; s < NSP; s++) begin
         y = int'(oam_m[s*4]);
         exp_lat += 2;
         if (line >= y && line - y < h) begin
            if (exp_cnt == NSL) begin
               exp_ovf = 1;
               break;
            end
            for (int b = 0; b < 4; b++) exp_sec[exp_cnt*4+b] = oam_m[s*4+b];
            if (s == 0) exp_sp0 = 1;
            exp_cnt++;
            exp_lat += 6;
         end
      end
   endtask

   task automatic set_addr(input logic [7:0] a);
      cpu_addr_we = 1'b1;
      cpu_wdata   = a;
      tick();
      cpu_addr_we = 1'b0;
   endtask

   task automatic drive_data(input logic [7:0] d);
      cpu_data_we = 1'b1;
      cpu_wdata   = d;
      tick();
      cpu_data_we = 1'b0;
   endtask

   task automatic fill_oam();
      set_addr(8'h00);
      for (int i = 0; i < NSP*4; i++) drive_data(oam_m[i]);
   endtask

   task automatic read_chk(input int a, input string tag);
      set_addr(a[7:0]);
      tick();
      check(tag, 32'(cpu_rdata), 32'(rmask(a, oam_m[a])));
   endtask

   task automatic start_eval(input logic [7:0] line, input bit t);
      eval_model(int'(line), t);
      eval_start = 1'b1;
      scan_line  = line;
      tall       = t;
      tick();
      eval_start = 1'b0;
      cyc = 1;
      check("busy_at_start", 32'(eval_busy), 32'd1);
      check("count_zeroed", 32'(sp_count), 32'd0);
      check("ovf_zeroed", 32'(sp_overflow), 32'd0);
      check("sp0_zeroed", 32'(sp0_in_range), 32'd0);
   endtask

   task automatic wait_done_and_check(input string tag);
      while (!eval_done && cyc < 2000) step();
      check({tag, "_latency"}, cyc, exp_lat);
      tick();
      check({tag, "_done_pulse"}, 32'(eval_done), 32'd0);
      check({tag, "_busy_clear"}, 32'(eval_busy), 32'd0);
      check({tag, "_count"}, 32'(sp_count), 32'(exp_cnt));
      check({tag, "_overflow"}, 32'(sp_overflow), 32'(exp_ovf));
      check({tag, "_sp0"}, 32'(sp0_in_range), 32'(exp_sp0));
      for (int i = 0; i < NSL*4; i++) begin
         sec_idx = i[4:0];
         tick();
         check({tag, "_sec"}, 32'(sec_data), 32'(exp_sec[i]));
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < NSP*4; i++) oam_m[i] = 8'hFF;
   endtask

   initial begin
      // reset values
      tick();
      tick();
      check("rst_rdata", 32'(cpu_rdata), 32'd0);
      check("rst_secdata", 32'(sec_data), 32'd0);
      check("rst_busy", 32'(eval_busy), 32'd0);
      check("rst_done", 32'(eval_done), 32'd0);
      check("rst_count", 32'(sp_count), 32'd0);
      check("rst_ovf", 32'(sp_overflow), 32'd0);
      check("rst_sp0", 32'(sp0_in_range), 32'd0);
      rst = 1'b0;
      tick();

      // CPU port
      clear_model();
      fill_oam();
      set_addr(8'h10);
      drive_data(8'h20); oam_m[8'h10] = 8'h20;
      drive_data(8'hE3); oam_m[8'h11] = 8'hE3;
      drive_data(8'h55); oam_m[8'h12] = 8'h55;
      drive_data(8'h9A); oam_m[8'h13] = 8'h9A;
      read_chk(8'h10, "cpu_rd_10");
      read_chk(8'h11, "cpu_rd_11");
      read_chk(8'h12, "cpu_rd_attr_mask");
      check("cpu_attr_value", 32'(cpu_rdata), 32'h41);
      read_chk(8'h13, "cpu_rd_autoinc");
      // address and data write together: address wins, data dropped
      cpu_addr_we = 1'b1;
      cpu_data_we = 1'b1;
      cpu_wdata   = 8'h2C;
      tick();
      cpu_addr_we = 1'b0;
      cpu_data_we = 1'b0;
      tick();
      check("both_we_addr", 32'(cpu_rdata), 32'(oam_m[8'h2C]));
      read_chk(8'h13, "both_we_nodata");
      // OAMADDR wrap
      set_addr(8'hFF);
      drive_data(8'h5C); oam_m[8'hFF] = 8'h5C;
      drive_data(8'h3B); oam_m[8'h00] = 8'h3B;
      read_chk(8'hFF, "wrap_ff");
      read_chk(8'h00, "wrap_00");

      // single hit
      clear_model();
      oam_m[20] = 8'h30; oam_m[21] = 8'h41; oam_m[22] = 8'h02; oam_m[23] = 8'h88;
      fill_oam();
      start_eval(8'h35, 1'b0);
      check("single_model_lat", exp_lat, 167);
      wait_done_and_check("single");

      // height boundaries
      start_eval(8'h37, 1'b0); wait_done_and_check("h8_last_row");
      start_eval(8'h38, 1'b0); wait_done_and_check("h8_past");
      start_eval(8'h38, 1'b1); wait_done_and_check("h16_row8");
      start_eval(8'h2F, 1'b0); wait_done_and_check("above_h8");
      start_eval(8'h2F, 1'b1); wait_done_and_check("above_h16");

      // overflow
      clear_model();
      for (int s = 0; s < 9; s++) begin
         oam_m[s*4]   = 8'h10;
         oam_m[s*4+1] = 8'(s + 1);
         oam_m[s*4+2] = 8'($urandom_range(0, 255));
         oam_m[s*4+3] = 8'($urandom_range(0, 255));
      end
      fill_oam();
      start_eval(8'h12, 1'b0);
      wait_done_and_check("overflow");

      // randomized OAM contents
      for (int r = 0; r < 4; r++) begin
         for (int s = 0; s < NSP; s++) begin
            oam_m[s*4] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(8'h20, 8'h60));
            for (int b = 1; b < 4; b++) oam_m[s*4+b] = 8'($urandom_range(0, 255));
         end
         fill_oam();
         start_eval(8'($urandom_range(8'h20, 8'h70)), 1'($urandom_range(0, 1)));
         wait_done_and_check("random");
      end

      // write lockout while busy
      clear_model();
      oam_m[8'h40] = 8'h12; oam_m[8'h41] = 8'h34; oam_m[8'h44] = 8'h56;
      fill_oam();
      set_addr(8'h40);
      start_eval(8'h90, 1'b0);
      repeat (5) step();
      cpu_data_we = 1'b1;
      cpu_wdata   = 8'hAB;
      step();
      cpu_data_we = 1'b0;
      wait_done_and_check("lockout_data");
      check("lockout_addr_held", 32'(cpu_rdata), 32'(oam_m[8'h40]));
      read_chk(8'h41, "lockout_next_byte");
      set_addr(8'h40);
      start_eval(8'h90, 1'b0);
      repeat (5) step();
      cpu_addr_we = 1'b1;
      cpu_wdata   = 8'h44;
      step();
      cpu_addr_we = 1'b0;
      wait_done_and_check("lockout_addr");
      check("busy_addr_write", 32'(cpu_rdata), 32'(oam_m[8'h44]));

      // restart mid-STORE: sprite 0 copied by cycle 40, cycle 44 is a STORE
      clear_model();
      oam_m[0] = 8'h10; oam_m[1] = 8'h21; oam_m[2] = 8'h22; oam_m[3] = 8'h23;
      fill_oam();
      start_eval(8'h12, 1'b0);
      while (cyc < 44) step();
      check("mid_count", 32'(sp_count), 32'd1);
      check("mid_sp0", 32'(sp0_in_range), 32'd1);
      start_eval(8'h80, 1'b0);
      wait_done_and_check("restart");

      // reset mid-scan
      start_eval(8'h12, 1'b0);
      repeat (50) step();
      rst = 1'b1;
      tick();
      check("rst_mid_rdata", 32'(cpu_rdata), 32'd0);
      check("rst_mid_secdata", 32'(sec_data), 32'd0);
      check("rst_mid_busy", 32'(eval_busy), 32'd0);
      check("rst_mid_done", 32'(eval_done), 32'd0);
      check("rst_mid_count", 32'(sp_count), 32'd0);
      check("rst_mid_ovf", 32'(sp_overflow), 32'd0);
      check("rst_mid_sp0", 32'(sp0_in_range), 32'd0);
      rst = 1'b0;
      tick();
      tick();
      check("rst_mid_addr0", 32'(cpu_rdata), 32'(oam_m[0]));
      check("rst_mid_idle", 32'(eval_busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
